// File: rtl/full_adder.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : full_adder
//  Description : Registered, width-parameterised ripple-carry full adder.
//                {Cout,S} = A + B + Cin, captured on in_valid with one cycle
//                of latency. The carry chain is built from explicit 1-bit
//                full-adder cells. WIDTH legal range is 1..64.
//                Optional macro FULL_ADDER_OVF_EN adds a registered
//                two's-complement overflow output (ovf).
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] S,
   output logic             Cout
`ifdef FULL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Per-bit sum from the cell array.
   logic [WIDTH-1:0] w_sum;
   // Carry out of the top cell (c_WIDTH) and carry into it (c_WIDTH-1).
   logic             w_carry_top;
   logic             w_carry_msb_in;

   logic             r_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   // Ripple-carry chain of 1-bit full-adder cells. Each cell keeps its own
   // carry-in/carry-out nets so the chain is a simple linear netlist.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         logic w_c_in;
         logic w_c_out;
         logic w_p;

         if (gi == 0) begin : g_first
            assign w_c_in = Cin;
         end else begin : g_next
            assign w_c_in = g_cell[gi-1].w_c_out;
         end

         // Propagate term shared by the sum and the carry.
         assign w_p       = A[gi] ^ B[gi];
         assign w_sum[gi] = w_p ^ w_c_in;
         assign w_c_out   = (A[gi] & B[gi]) | (w_c_in & w_p);
      end
   endgenerate

   assign w_carry_top    = g_cell[WIDTH-1].w_c_out;
   assign w_carry_msb_in = g_cell[WIDTH-1].w_c_in;

   // Output register: reset wins, capture on in_valid, hold data when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_carry_top;
         end
      end
   end

   assign out_valid = r_valid;
   assign S         = r_sum;
   assign Cout      = r_cout;

`ifdef FULL_ADDER_OVF_EN
   logic r_ovf;

   // Signed overflow: carry into and out of the sign bit disagree.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (in_valid) begin
         r_ovf <= w_carry_top ^ w_carry_msb_in;
      end
   end

   assign ovf = r_ovf;
`else
   // Carry into the sign bit only feeds the overflow flag.
   logic w_unused_msb_in;
   assign w_unused_msb_in = w_carry_msb_in;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_full_adder
//  Description : Self-checking bench for full_adder at WIDTH=1 and WIDTH=8,
//                directed cases plus randomized traffic against an
//                arithmetic reference model.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_full_adder;

   logic       clk = 1'b0;
   logic       rst;

   logic       v1, a1, b1, c1;
   logic       ov1, s1, co1;
   logic       v8, c8;
   logic [7:0] a8, b8, s8;
   logic       ov8, co8;
`ifdef FULL_ADDER_OVF_EN
   logic       o1, o8;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state (expected registered outputs).
   logic       m_v1, m_s1, m_co1, m_o1;
   logic       m_v8, m_co8, m_o8;
   logic [7:0] m_s8;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v1),
      .A         (a1),
      .B         (b1),
      .Cin       (c1),
      .out_valid (ov1),
      .S         (s1),
      .Cout      (co1)
`ifdef FULL_ADDER_OVF_EN
      ,
      .ovf       (o1)
`endif
   );

   full_adder #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v8),
      .A         (a8),
      .B         (b8),
      .Cin       (c8),
      .out_valid (ov8),
      .S         (s8),
      .Cout      (co8)
`ifdef FULL_ADDER_OVF_EN
      ,
      .ovf       (o8)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock, update the model from the sampled inputs, then
   // compare every output shortly after the edge.
   task automatic cycle(input string ph);
      int sum, sv;
      @(posedge clk);
      if (rst) begin
         m_v1 = 0; m_s1 = 0; m_co1 = 0; m_o1 = 0;
         m_v8 = 0; m_s8 = 0; m_co8 = 0; m_o8 = 0;
      end else begin
         m_v1 = v1;
         if (v1) begin
            sum   = int'(a1) + int'(b1) + int'(c1);
            m_s1  = (sum % 2) == 1;
            m_co1 = sum >= 2;
            sv    = (a1 ? -1 : 0) + (b1 ? -1 : 0) + int'(c1);
            m_o1  = (sv > 0) || (sv < -1);
         end
         m_v8 = v8;
         if (v8) begin
            sum   = int'(a8) + int'(b8) + int'(c8);
            m_s8  = 8'(sum % 256);
            m_co8 = sum >= 256;
            sv    = int'($signed(a8)) + int'($signed(b8)) + int'(c8);
            m_o8  = (sv > 127) || (sv < -128);
         end
      end
      #1;
      check({ph, ".v1"},  64'(ov1), 64'(m_v1));
      check({ph, ".s1"},  64'(s1),  64'(m_s1));
      check({ph, ".co1"}, 64'(co1), 64'(m_co1));
      check({ph, ".v8"},  64'(ov8), 64'(m_v8));
      check({ph, ".s8"},  64'(s8),  64'(m_s8));
      check({ph, ".co8"}, 64'(co8), 64'(m_co8));
`ifdef FULL_ADDER_OVF_EN
      check({ph, ".o1"},  64'(o1),  64'(m_o1));
      check({ph, ".o8"},  64'(o8),  64'(m_o8));
`endif
   endtask

   initial begin
      logic [2:0] vec1 [5];
      logic [7:0] va8  [5];
      logic [7:0] vb8  [5];
      logic       vc8  [5];

      vec1 = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b111};
      va8  = '{8'hFF, 8'hFF, 8'h3C, 8'h7F, 8'hFF};
      vb8  = '{8'h01, 8'hFF, 8'h42, 8'h01, 8'h01};
      vc8  = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

      // Reset held two cycles, then released with no valid input.
      rst = 1; v1 = 0; a1 = 0; b1 = 0; c1 = 0;
      v8 = 0; a8 = 0; b8 = 0; c8 = 0;
      cycle("rst");
      cycle("rst");
      rst = 0;
      cycle("idle");
      cycle("idle");

      // Back-to-back directed vectors on both widths.
      for (int i = 0; i < 5; i++) begin
         v1 = 1; {a1, b1, c1} = vec1[i];
         v8 = 1; a8 = va8[i]; b8 = vb8[i]; c8 = vc8[i];
         cycle("dir");
      end

      // Absolute spot checks on the last directed results.
      check("dir.last_s1",  64'(s1),  64'(1));
      check("dir.last_co1", 64'(co1), 64'(1));
      check("dir.last_s8",  64'(s8),  64'(8'h00));
      check("dir.last_co8", 64'(co8), 64'(1));

      // Capture then idle with random inputs; data must hold.
      v1 = 1; a1 = 1; b1 = 1; c1 = 0;
      v8 = 1; a8 = 8'h80; b8 = 8'h80; c8 = 0;
      cycle("cap");
      for (int i = 0; i < 5; i++) begin
         v1 = 0; {a1, b1, c1} = 3'($urandom);
         v8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
         cycle("hold");
         check("hold.s1_abs",  64'(s1),  64'(0));
         check("hold.co1_abs", 64'(co1), 64'(1));
      end

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         v1 = ($urandom_range(0, 3) != 0); {a1, b1, c1} = 3'($urandom);
         v8 = ($urandom_range(0, 3) != 0);
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
         cycle("rnd");
      end
      rst = 0;

      // Load a known result, then assert reset alongside a valid capture.
      v1 = 1; a1 = 1; b1 = 1; c1 = 1;
      v8 = 1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
      cycle("pre");
      rst = 1; v1 = 1; a1 = 1; b1 = 0; c1 = 0;
      v8 = 1; a8 = 8'h12; b8 = 8'h34; c8 = 0;
      cycle("midrst");
      check("midrst.s8_abs", 64'(s8), 64'(0));
      rst = 0; v1 = 0; v8 = 0;
      cycle("post");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered, width-parameterised binary full adder: S/Cout = A + B + Cin.
- Default configuration (WIDTH=1) is the classic 1-bit full-adder cell, with outputs registered on one clock.
- Used as a leaf arithmetic primitive.
- Wider instances chain WIDTH single-bit full-adder stages (ripple carry) inside one registered stage.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  qualifies A/B/Cin this cycle.
- A  input  WIDTH  operand A (unsigned).
- B  input  WIDTH  operand B (unsigned).
- Cin  input  1  carry-in to bit 0.
- out_valid  output  1  S/Cout hold a fresh result this cycle.
- S  output  WIDTH  registered sum bits.
- Cout  output  1  registered carry-out from bit WIDTH-1.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, the block drives S=0, Cout=0, out_valid=0. Reset has priority over in_valid.
- Reset mid-operation: a result captured in the same cycle as rst=1 is discarded.
- Arithmetic per bit i, with c0 = Cin:
  - s_i = A_i ^ B_i ^ c_i
  - c_(i+1) = (A_i & B_i) | (c_i & (A_i ^ B_i))
  - Cout = c_WIDTH
  - Equivalently {Cout,S} = A + B + Cin, computed at WIDTH+1 bits with no truncation.
- Capture: on a rising edge with rst=0 and in_valid=1, the block registers S and Cout from the current A/B/Cin and sets out_valid=1.
- Latency: exactly 1 cycle from input sample to registered output.
- Throughput: one operation per cycle; back-to-back in_valid is supported with no bubbles.
- Idle: on a rising edge with rst=0 and in_valid=0, out_valid goes to 0 and S/Cout hold their last values (no X, no clearing).
- Wrap-around: if A + B + Cin >= 2^WIDTH, S holds the low WIDTH bits and Cout=1.
  - Maximum case: A = B = all-ones with Cin=1 gives S = all-ones, Cout=1.
- No combinational path from any input to any output.
- X/Z on A/B/Cin while in_valid=0 must not affect outputs.
- Implementation: the carry chain is a generate loop of 1-bit full-adder cells, not a single '+' operator, so the gate-level cell is explicit.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered). ovf = c_WIDTH ^ c_(WIDTH-1), i.e. two's-complement signed overflow.
  - For WIDTH=1, c_(WIDTH-1) is Cin.
  - ovf resets to 0 with the other outputs, updates only on capture, and holds when idle.
- Not defined: port ovf does not exist and no related logic is synthesised. All other behaviour is identical.

Test Plan:
- WIDTH=1, rst=1 for 2 cycles, then release -> S=0, Cout=0, out_valid=0 during and after reset until the first in_valid.
- WIDTH=1, in_valid=1, apply (A,B,Cin) in order (0,0,0), (0,0,1), (0,1,0), (1,0,1), (1,1,1), one per cycle. Each result appears 1 cycle later as (S,Cout):
  - (0,0,0) -> (0,0)
  - (0,0,1) -> (1,0)
  - (0,1,0) -> (1,0)
  - (1,0,1) -> (0,1)
  - (1,1,1) -> (1,1)
  - out_valid stays 1 throughout.
- WIDTH=8:
  - A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1.
  - A=8'hFF, B=8'hFF, Cin=1 -> S=8'hFF, Cout=1.
  - A=8'h3C, B=8'h42, Cin=1 -> S=8'h7F, Cout=0.
- Hold: capture A=1,B=1,Cin=0 (S=0, Cout=1), then in_valid=0 with random A/B/Cin for 5 cycles -> S=0, Cout=1 held; out_valid=0 from the cycle after in_valid drops.
- Reset mid-stream: in_valid=1 with A=1,B=0,Cin=0 and rst=1 on the same edge -> S=0, Cout=0, out_valid=0 after that edge.
- With FULL_ADDER_OVF_EN, WIDTH=8:
  - A=8'h7F, B=8'h01, Cin=0 -> S=8'h80, Cout=0, ovf=1.
  - A=8'hFF, B=8'h01, Cin=0 -> ovf=0.
